// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl -- time-multiplexed 7-segment scan controller.
//
// Scans NUM_DIGITS digits that share one segment bus. Each digit owns a slot
// of CLK_DIV clock cycles. A slot opens with BLANK_CYCLES dead cycles during
// which no enable is active, so the previous digit's segments cannot ghost
// onto the next digit. The digit is then lit for a brightness-dependent
// fraction of the remaining ACTIVE cycles. New content is loaded into shadow
// registers and copied to the display registers only at a frame boundary,
// so a frame is never torn.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   glyph       5-bit glyph code per digit, digit i at [5i+4:5i]
//               (0..15 hex, 16 blank, 17 dash, 18..31 blank)
//   dp          decimal point per digit
//   digit_mask  1 = digit lit
//   brightness  duty level 0..15 (15 = whole active window)
//   load        one-cycle strobe capturing glyph/dp/digit_mask/brightness
//   seg_en      one-hot digit enable (active-low when EN_ACTIVE_LOW=1)
//   seg_out     segments {a,b,c,d,e,f,g,dp} (active-low when SEG_ACTIVE_LOW=1)
//   frame_done  one-cycle pulse after the last slot of each frame
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int EN_ACTIVE_LOW  = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*NUM_DIGITS-1:0] glyph,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   seg_en,
    output logic [7:0]              seg_out,
    output logic                    frame_done
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Wide enough for ACTIVE*(brightness+1) without losing the top bits.
    localparam int W      = CNT_W + 6;
    localparam int ACTIVE = CLK_DIV - BLANK_CYCLES;

    localparam logic [W-1:0] ACTIVE_W = W'(ACTIVE);
    localparam logic [W-1:0] BLANK_W  = W'(BLANK_CYCLES);

    // Active-high segment pattern for a glyph code; dp is OR-ed in separately.
    function automatic logic [7:0] decode_glyph(input logic [4:0] g);
        logic [7:0] s;
        case (g)
            5'd0:    s = 8'hFC;
            5'd1:    s = 8'h60;
            5'd2:    s = 8'hDA;
            5'd3:    s = 8'hF2;
            5'd4:    s = 8'h66;
            5'd5:    s = 8'hB6;
            5'd6:    s = 8'hBE;
            5'd7:    s = 8'hE0;
            5'd8:    s = 8'hFE;
            5'd9:    s = 8'hF6;
            5'd10:   s = 8'hEE;
            5'd11:   s = 8'h3E;
            5'd12:   s = 8'h9C;
            5'd13:   s = 8'h7A;
            5'd14:   s = 8'h9E;
            5'd15:   s = 8'h8E;
            5'd17:   s = 8'h02;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Scan counters
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;

    // Display registers (what is being shown this frame)
    logic [5*NUM_DIGITS-1:0] disp_glyph_q, disp_glyph_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   disp_mask_q, disp_mask_d;
    logic [3:0]              disp_bright_q, disp_bright_d;

    // Shadow registers (next frame's content); only meaningful while pending_q
    logic [5*NUM_DIGITS-1:0] sh_glyph_q, sh_glyph_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_mask_q, sh_mask_d;
    logic [3:0]              sh_bright_q, sh_bright_d;
    logic                    pending_q, pending_d;

    // Registered outputs, active-high before polarity inversion
    logic [NUM_DIGITS-1:0] seg_en_q, seg_en_d;
    logic [7:0]            seg_out_q, seg_out_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_wrap, idx_wrap, frame_end;
    logic [4:0]            cur_glyph;
    logic                  cur_dp, cur_mask;
    logic [NUM_DIGITS-1:0] digit_onehot;
    logic [W-1:0]          on_prod, on_len, slot_ext, window_end;
    logic                  lit;

    // Counter stage
    always_comb begin
        slot_wrap   = (slot_cnt_q == CNT_W'(CLK_DIV - 1));
        idx_wrap    = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_end   = slot_wrap && idx_wrap;
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_wrap) begin
            digit_idx_d = idx_wrap ? '0 : digit_idx_q + 1'b1;
        end
    end

    // Double-buffer control: a load at the boundary itself bypasses the shadow.
    always_comb begin
        disp_glyph_d  = disp_glyph_q;
        disp_dp_d     = disp_dp_q;
        disp_mask_d   = disp_mask_q;
        disp_bright_d = disp_bright_q;
        sh_glyph_d    = sh_glyph_q;
        sh_dp_d       = sh_dp_q;
        sh_mask_d     = sh_mask_q;
        sh_bright_d   = sh_bright_q;
        pending_d     = pending_q;
        if (frame_end) begin
            if (load) begin
                disp_glyph_d  = glyph;
                disp_dp_d     = dp;
                disp_mask_d   = digit_mask;
                disp_bright_d = brightness;
            end else if (pending_q) begin
                disp_glyph_d  = sh_glyph_q;
                disp_dp_d     = sh_dp_q;
                disp_mask_d   = sh_mask_q;
                disp_bright_d = sh_bright_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            sh_glyph_d  = glyph;
            sh_dp_d     = dp;
            sh_mask_d   = digit_mask;
            sh_bright_d = brightness;
            pending_d   = 1'b1;
        end
    end

    // Current digit selection
    always_comb begin
        cur_glyph    = 5'd16;
        cur_dp       = 1'b0;
        cur_mask     = 1'b0;
        digit_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
                cur_glyph       = disp_glyph_q[5*i +: 5];
                cur_dp          = disp_dp_q[i];
                cur_mask        = disp_mask_q[i];
                digit_onehot[i] = 1'b1;
            end
        end
    end

    // Brightness window and output decode
    always_comb begin
        on_prod    = ACTIVE_W * (W'(disp_bright_q) + W'(1));
        on_len     = on_prod >> 4;
        slot_ext   = W'(slot_cnt_q);
        window_end = BLANK_W + on_len;
        lit        = cur_mask && (slot_ext >= BLANK_W) && (slot_ext < window_end);
        seg_en_d     = lit ? digit_onehot : '0;
        seg_out_d    = lit ? (decode_glyph(cur_glyph) | {7'b0, cur_dp}) : 8'h00;
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            disp_glyph_q  <= {NUM_DIGITS{5'd16}};
            disp_dp_q     <= '0;
            disp_mask_q   <= '0;
            disp_bright_q <= 4'd15;
            pending_q     <= 1'b0;
            seg_en_q      <= '0;
            seg_out_q     <= 8'h00;
            frame_done_q  <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            disp_glyph_q  <= disp_glyph_d;
            disp_dp_q     <= disp_dp_d;
            disp_mask_q   <= disp_mask_d;
            disp_bright_q <= disp_bright_d;
            pending_q     <= pending_d;
            seg_en_q      <= seg_en_d;
            seg_out_q     <= seg_out_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Shadow data is qualified by pending_q, so it needs no reset.
    always_ff @(posedge clk) begin
        sh_glyph_q  <= sh_glyph_d;
        sh_dp_q     <= sh_dp_d;
        sh_mask_q   <= sh_mask_d;
        sh_bright_q <= sh_bright_d;
    end

    // Polarity stage: pure inversion after the flops, so reset = inactive level.
    assign seg_en     = (EN_ACTIVE_LOW != 0)  ? ~seg_en_q  : seg_en_q;
    assign seg_out    = (SEG_ACTIVE_LOW != 0) ? ~seg_out_q : seg_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised, time-multiplexed 7-segment scan controller for NUM_DIGITS common-enable digits sharing one segment bus.
- Adds over the fixed 8-digit driver:
  - 5-bit glyph codes (hex, blank, dash) and a per-digit decimal point.
  - Per-digit mask and programmable brightness (PWM within each slot).
  - Anti-ghosting dead time between digits.
  - Tear-free double-buffered update applied at frame boundaries.
- Sits between the MMIO display register block and the board pins.

Parameters:
- NUM_DIGITS, 8, digits scanned (1..16).
- CLK_DIV, 100000, clk cycles per digit slot; must be >= BLANK_CYCLES+16.
- BLANK_CYCLES, 1000, dead cycles at the start of each slot with all enables inactive.
- EN_ACTIVE_LOW, 0, 1 = seg_en pins active-low.
- SEG_ACTIVE_LOW, 0, 1 = seg_out pins active-low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- glyph  in  5*NUM_DIGITS  code per digit; digit i at [5i+4:5i].
- dp  in  NUM_DIGITS  decimal point per digit.
- digit_mask  in  NUM_DIGITS  1 = digit lit.
- brightness  in  4  duty level 0..15.
- load  in  1  one-cycle strobe: capture glyph/dp/digit_mask/brightness.
- seg_en  out  NUM_DIGITS  one-hot digit enable (polarity per EN_ACTIVE_LOW).
- seg_out  out  8  segments: [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=dp (polarity per SEG_ACTIVE_LOW).
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (asynchronous, rst_n low):
  - slot_cnt=0, digit_idx=0, pending=0.
  - Display regs: glyph=16 (blank), dp=0, mask=0, brightness=15.
  - seg_en and seg_out at inactive level; frame_done=0.
- Reset mid-frame aborts the scan immediately, with no glitch beyond the asynchronous clear.
- Counters:
  - slot_cnt counts 0..CLK_DIV-1.
  - On wrap, digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
  - frame_done=1 on the cycle after the digit_idx wrap; the scan never stalls.
- Window within slot:
  - ACTIVE = CLK_DIV - BLANK_CYCLES.
  - on_len = (ACTIVE*(brightness+1))>>4, using a full-width product.
  - Digit lit while BLANK_CYCLES <= slot_cnt < BLANK_CYCLES+on_len and mask[digit_idx]=1.
  - brightness=15 gives on_len = ACTIVE (no truncation loss).
- Outputs are registered, with 1-cycle latency from the counter state.
  - Lit: seg_en one-hot at digit_idx; seg_out = decode(glyph) | dp.
  - Unlit: all seg_en inactive, seg_out=0 (before polarity inversion).
  - At most one seg_en is ever active, and never during the first BLANK_CYCLES cycles of any slot.
- Glyph decode (active-high):
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6
  - A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
  - 16=00 (blank), 17=02 (dash), 18..31=00.
  - dp ORs bit 0.
- Double buffering:
  - load=1 captures all inputs into shadow regs and sets pending.
  - A later load before the boundary overwrites the shadow (last wins).
  - At the frame boundary (the cycle digit_idx wraps to 0) with pending=1: shadow copies to display regs and pending clears.
  - load on the same cycle as the boundary: the inputs go straight to display regs and pending stays 0.
  - Display regs never change mid-frame.
- Polarity: invert seg_en and/or seg_out after the register stage per parameters. The reset level is the inactive level.

Test Plan:
- Bench parameters NUM_DIGITS=4, CLK_DIV=20, BLANK_CYCLES=4; no load after reset:
  - Required: seg_en=0 and seg_out=0 for 3 frames.
  - Required: frame_done pulses every 80 cycles.
- load with glyph={3,2,1,0}, dp=4'b0001, mask=4'hF, brightness=15:
  - From the next frame, the digit 0 slot shows seg_out=FD for 16 cycles after 4 dead cycles.
  - Digit 3 shows F2.
  - Never two enables active.
- brightness=7, ACTIVE=16:
  - Required: each digit lit exactly 8 cycles per slot, starting at slot_cnt=4 (+1 latency).
- mask=4'b1010, glyph=17:
  - Digits 1 and 3 show 02; digits 0 and 2 dark.
  - Frame period unchanged at 80 cycles.
- load pulsed mid-frame at digit 1, then again at digit 2 with different glyphs:
  - Current frame unchanged; only the second set appears from the next frame.
  - load coincident with the wrap cycle applies at that same boundary.
- EN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1:
  - Reset gives seg_en=4'hF and seg_out=FF.
  - Glyph 8 at full brightness drives seg_out=01 while lit.
  - Asserting rst_n low mid-slot returns all outputs to the inactive level immediately.
